// File: rtl/card_pkg.sv
// Shared types and constants for the card dealer: deck geometry, card
// field types (rank 1..13, suit 0..3) and the dealer FSM state encoding.
// Latency: n/a (types only). Backpressure: n/a.
package card_pkg;

  localparam int NUM_CARDS      = 52;
  localparam int RANKS_PER_SUIT = 13;
  localparam int NUM_SUITS      = 4;
  localparam int CARD_IDX_W     = 6;   // holds indices 0..51

  typedef logic [3:0] rank_t;

  typedef enum logic [1:0] {
    SUIT_CLUBS    = 2'd0,
    SUIT_DIAMONDS = 2'd1,
    SUIT_HEARTS   = 2'd2,
    SUIT_SPADES   = 2'd3
  } suit_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_PROBE = 3'd4,
    ST_DONE  = 3'd5
  } dealer_state_t;

endpackage

// File: rtl/card_index_decode.sv
// Maps a deck index 0..51 to {rank, suit}: suit = idx/13, rank = idx%13 + 1.
// Latency: combinational. Backpressure: none; output follows input.
// Ports: idx_i (card index), rank_o (1..13), suit_o (0..3).
module card_index_decode
  import card_pkg::*;
(
  input  logic [CARD_IDX_W-1:0] idx_i,
  output rank_t                 rank_o,
  output suit_t                 suit_o
);

  localparam logic [CARD_IDX_W-1:0] BASE_D = CARD_IDX_W'(RANKS_PER_SUIT);
  localparam logic [CARD_IDX_W-1:0] BASE_H = CARD_IDX_W'(2 * RANKS_PER_SUIT);
  localparam logic [CARD_IDX_W-1:0] BASE_S = CARD_IDX_W'(3 * RANKS_PER_SUIT);

  logic [3:0] offset;

  // Three threshold compares and one subtract replace a divide-by-13.
  always_comb begin
    offset = idx_i[3:0];
    suit_o = SUIT_CLUBS;
    if (idx_i >= BASE_S) begin
      suit_o = SUIT_SPADES;
      offset = 4'(idx_i - BASE_S);
    end else if (idx_i >= BASE_H) begin
      suit_o = SUIT_HEARTS;
      offset = 4'(idx_i - BASE_H);
    end else if (idx_i >= BASE_D) begin
      suit_o = SUIT_DIAMONDS;
      offset = 4'(idx_i - BASE_D);
    end
    rank_o = offset + 4'd1;
  end

endmodule

// File: rtl/card_dealer.sv
// Deals cards without replacement from one 52-card deck using a random index
// and a linear probe over a dealt mask; card presented with a 1-cycle valid.
// Latency: deal -> valid 5 cycles plus 1 per occupied slot probed (max +51).
// Backpressure: none; i_deal is only accepted in IDLE, o_card_valid is a pulse.
// Ports: i_clk/i_reset; i_deal, i_shuffle requests; i_rand_value from RNG;
//        o_rand_request/o_rand_max to RNG; o_card_rank/suit/valid to game FSM;
//        o_busy, o_empty, o_cards_left status.
module card_dealer #(
  parameter int NUM_CARDS  = card_pkg::NUM_CARDS,
  parameter int RAND_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_deal,
  input  logic                  i_shuffle,
  input  logic [RAND_WIDTH-1:0] i_rand_value,
  output logic                  o_rand_request,
  output logic [RAND_WIDTH-1:0] o_rand_max,
  output logic [3:0]            o_card_rank,
  output logic [1:0]            o_card_suit,
  output logic                  o_card_valid,
  output logic                  o_busy,
  output logic                  o_empty,
  output logic [5:0]            o_cards_left
);

  localparam int IDX_W = card_pkg::CARD_IDX_W;
  localparam logic [RAND_WIDTH-1:0] DECK_SIZE_R = RAND_WIDTH'(NUM_CARDS);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_CARDS - 1);
  localparam logic [5:0]            FULL_COUNT  = 6'(NUM_CARDS);

  card_pkg::dealer_state_t state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_CARDS-1:0]    mask_q, mask_d;
  logic [5:0]              left_q, left_d;
  logic                    empty_q, empty_d;
  card_pkg::rank_t         rank_q, rank_d;
  card_pkg::suit_t         suit_q, suit_d;

  card_pkg::rank_t         dec_rank;
  card_pkg::suit_t         dec_suit;
  logic [RAND_WIDTH-1:0]   folded;

  // The generator never exceeds 2*NUM_CARDS-1, so one subtract folds it.
  assign folded = (i_rand_value >= DECK_SIZE_R) ? (i_rand_value - DECK_SIZE_R)
                                                : i_rand_value;

  card_index_decode u_decode (
    .idx_i  (idx_q),
    .rank_o (dec_rank),
    .suit_o (dec_suit)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    left_d  = left_q;
    empty_d = empty_q;
    rank_d  = rank_q;
    suit_d  = suit_q;

    unique case (state_q)
      card_pkg::ST_IDLE: begin
        if (i_deal && !empty_q) state_d = card_pkg::ST_REQ;
      end
      card_pkg::ST_REQ:  state_d = card_pkg::ST_WAIT;
      card_pkg::ST_WAIT: state_d = card_pkg::ST_LOAD;
      card_pkg::ST_LOAD: begin
        idx_d   = folded[IDX_W-1:0];
        state_d = card_pkg::ST_PROBE;
      end
      card_pkg::ST_PROBE: begin
        if (!mask_q[idx_q]) begin
          mask_d[idx_q] = 1'b1;
          left_d        = left_q - 6'd1;
          rank_d        = dec_rank;
          suit_d        = dec_suit;
          state_d       = card_pkg::ST_DONE;
        end else begin
          // Never loops forever: a deal only starts with a free slot left.
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
      end
      card_pkg::ST_DONE: begin
        empty_d = (left_q == 6'd0);
        state_d = card_pkg::ST_IDLE;
      end
      default: state_d = card_pkg::ST_IDLE;
    endcase

    // Shuffle overrides everything, including a probe that just found a slot;
    // the displayed card keeps its previous value.
    if (i_shuffle) begin
      state_d = card_pkg::ST_IDLE;
      mask_d  = '0;
      left_d  = FULL_COUNT;
      empty_d = 1'b0;
      rank_d  = rank_q;
      suit_d  = suit_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= card_pkg::ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      left_q  <= FULL_COUNT;
      empty_q <= 1'b0;
      rank_q  <= '0;
      suit_q  <= card_pkg::SUIT_CLUBS;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      left_q  <= left_d;
      empty_q <= empty_d;
      rank_q  <= rank_d;
      suit_q  <= suit_d;
    end
  end

  assign o_rand_request = (state_q == card_pkg::ST_REQ);
  assign o_card_valid   = (state_q == card_pkg::ST_DONE);
  assign o_busy         = (state_q != card_pkg::ST_IDLE);
  assign o_rand_max     = RAND_WIDTH'(NUM_CARDS - 1);
  assign o_card_rank    = rank_q;
  assign o_card_suit    = suit_q;
  assign o_empty        = empty_q;
  assign o_cards_left   = left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a deck model predicts each dealt card,
// a negedge monitor checks every o_card_valid against the expected queue.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_deal = 1'b0;
  logic       i_shuffle = 1'b0;
  logic [5:0] i_rand_value = '0;
  logic       o_rand_request;
  logic [5:0] o_rand_max;
  logic [3:0] o_card_rank;
  logic [1:0] o_card_suit;
  logic       o_card_valid;
  logic       o_busy;
  logic       o_empty;
  logic [5:0] o_cards_left;

  card_dealer #(.NUM_CARDS(52), .RAND_WIDTH(6)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_deal         (i_deal),
    .i_shuffle      (i_shuffle),
    .i_rand_value   (i_rand_value),
    .o_rand_request (o_rand_request),
    .o_rand_max     (o_rand_max),
    .o_card_rank    (o_card_rank),
    .o_card_suit    (o_card_suit),
    .o_card_valid   (o_card_valid),
    .o_busy         (o_busy),
    .o_empty        (o_empty),
    .o_cards_left   (o_cards_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rank;
    int suit;
    int left;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   req_count = 0;

  // Deck model: which cards are out, and how many remain.
  bit   dealt[52];
  int   model_left = 52;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_shuffle();
    foreach (dealt[i]) dealt[i] = 1'b0;
    model_left = 52;
  endtask

  // Picks the card a draw of value v yields: first free slot at or after
  // v mod 52, scanning upward and wrapping; skips counts occupied slots seen.
  task automatic model_pick(input int v, output int idx, output int skips);
    idx   = v % 52;
    skips = 0;
    while (dealt[idx]) begin
      idx = (idx + 1) % 52;
      skips++;
    end
  endtask

  // Issues one deal and checks latency and request pulse count; the card
  // itself is checked by the monitor against the pushed expectation.
  task automatic do_deal(input int v);
    int idx, skips, lat, req0;
    exp_t e;
    model_pick(v, idx, skips);
    dealt[idx] = 1'b1;
    model_left--;
    e.rank = idx % 13 + 1;
    e.suit = idx / 13;
    e.left = model_left;
    exp_q.push_back(e);
    @(posedge clk); #1;
    i_rand_value = 6'(v);
    i_deal = 1'b1;
    req0 = req_count;
    @(posedge clk); #1;
    i_deal = 1'b0;
    lat = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (o_card_valid) begin
        lat = c;
        break;
      end
    end
    chk("deal_latency", lat, 5 + skips);
    chk("rand_request_pulses", req_count - req0, 1);
  endtask

  // Monitor: counts generator requests and scores every presented card.
  always @(negedge clk) begin
    if (o_rand_request) req_count++;
    if (o_card_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: rank=%0d suit=%0d with no deal pending (t=%0t)",
                 o_card_rank, o_card_suit, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("card_rank", int'(o_card_rank), mon_e.rank);
        chk("card_suit", int'(o_card_suit), mon_e.suit);
        chk("cards_left", int'(o_cards_left), mon_e.left);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expected cards pending",
             exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen[52];
    int req0, didx, v;

    // Reset and idle.
    #23;
    @(negedge clk);
    i_reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_cards_left", int'(o_cards_left), 52);
    chk("reset_empty", int'(o_empty), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("rand_max", int'(o_rand_max), 51);
    chk("reset_rank", int'(o_card_rank), 0);
    chk("reset_suit", int'(o_card_suit), 0);
    chk("idle_no_request", req_count, 0);

    // Basic draws, collision, wrap and fold of an out-of-range value.
    do_deal(0);
    do_deal(25);
    do_deal(5);
    do_deal(5);
    do_deal(51);
    do_deal(51);
    do_deal(60);

    // Shuffle together with deal: shuffle wins, deal dropped.
    @(posedge clk); #1;
    req0 = req_count;
    i_deal = 1'b1;
    i_shuffle = 1'b1;
    @(posedge clk); #1;
    i_deal = 1'b0;
    i_shuffle = 1'b0;
    repeat (10) @(negedge clk);
    model_shuffle();
    chk("shuffle_deal_no_request", req_count - req0, 0);
    chk("shuffle_deal_left", int'(o_cards_left), 52);
    chk("shuffle_deal_busy", int'(o_busy), 0);

    // Shuffle in the middle of a long probe.
    for (int k = 0; k < 6; k++) do_deal(k);
    @(posedge clk); #1;
    i_rand_value = 6'd0;
    i_deal = 1'b1;
    @(posedge clk); #1;
    i_deal = 1'b0;
    repeat (6) @(negedge clk);
    chk("probe_busy_before_shuffle", int'(o_busy), 1);
    i_shuffle = 1'b1;
    @(posedge clk); #1;
    i_shuffle = 1'b0;
    repeat (20) @(negedge clk);
    model_shuffle();
    chk("shuffle_probe_left", int'(o_cards_left), 52);
    chk("shuffle_probe_empty", int'(o_empty), 0);
    chk("shuffle_probe_busy", int'(o_busy), 0);
    do_deal(5);

    // Reset in the middle of a probe.
    for (int k = 0; k < 4; k++) do_deal(k);
    @(posedge clk); #1;
    i_rand_value = 6'd0;
    i_deal = 1'b1;
    @(posedge clk); #1;
    i_deal = 1'b0;
    repeat (5) @(negedge clk);
    i_reset = 1'b1;
    #1;
    chk("midprobe_reset_left", int'(o_cards_left), 52);
    chk("midprobe_reset_busy", int'(o_busy), 0);
    chk("midprobe_reset_rank", int'(o_card_rank), 0);
    chk("midprobe_reset_suit", int'(o_card_suit), 0);
    @(negedge clk);
    i_reset = 1'b0;
    model_shuffle();
    do_deal(2);

    // Exhaust the deck with random draws.
    @(posedge clk); #1;
    i_shuffle = 1'b1;
    @(posedge clk); #1;
    i_shuffle = 1'b0;
    model_shuffle();
    foreach (seen[i]) seen[i] = 1'b0;
    for (int n = 0; n < 52; n++) begin
      v = $urandom_range(0, 63);
      do_deal(v);
      didx = (int'(o_card_rank) - 1) + 13 * int'(o_card_suit);
      if (didx < 0 || didx > 51) begin
        chk("card_in_deck", didx, 0);
      end else begin
        chk("card_distinct", int'(seen[didx]), 0);
        seen[didx] = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    chk("exhausted_empty", int'(o_empty), 1);
    chk("exhausted_left", int'(o_cards_left), 0);

    // A deal on an empty deck is ignored.
    @(posedge clk); #1;
    req0 = req_count;
    i_rand_value = 6'd7;
    i_deal = 1'b1;
    @(posedge clk); #1;
    i_deal = 1'b0;
    repeat (10) @(negedge clk);
    chk("empty_deal_no_request", req_count - req0, 0);
    chk("empty_deal_busy", int'(o_busy), 0);
    chk("empty_deal_left", int'(o_cards_left), 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
Draws cards without replacement from a single 52-card deck for the blackjack game controller. It sits directly downstream of the random number generator: it drives that block's request and max inputs and consumes its value output. Each random index is mapped to a unique undealt card using a linear probe over a 52-bit dealt mask. The card is then presented to the game FSM as rank and suit with a one-cycle valid pulse.

Parameters:
NUM_CARDS, 52, deck size; card index range is 0..NUM_CARDS-1
RAND_WIDTH, 6, width of the random value bus; must satisfy 2**RAND_WIDTH >= NUM_CARDS

Ports:
i_clk  input  1  system clock, all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_deal  input  1  request one card; sampled only in IDLE
i_shuffle  input  1  return all cards to the deck; aborts any deal in flight
i_rand_value  input  RAND_WIDTH  value from the random number generator
o_rand_request  output  1  one-cycle pulse asking the generator for a new value
o_rand_max  output  RAND_WIDTH  constant NUM_CARDS-1 (51), wired to the generator's max
o_card_rank  output  4  rank 1..13 (1=Ace, 11=J, 12=Q, 13=K)
o_card_suit  output  2  suit 0=clubs, 1=diamonds, 2=hearts, 3=spades
o_card_valid  output  1  one-cycle pulse; rank and suit are valid in this cycle and hold until the next deal
o_busy  output  1  high in every state except IDLE
o_empty  output  1  high when all 52 cards have been dealt
o_cards_left  output  6  count of undealt cards, 0..52

Behaviour:
- Reset (asynchronous): state=IDLE; mask=0; o_cards_left=52; o_empty=0; o_busy=0; o_card_valid=0; o_rand_request=0; o_card_rank=0; o_card_suit=0.
- FSM states: IDLE, REQ, WAIT, LOAD, PROBE, DONE.
- IDLE: i_deal=1 and o_empty=0 -> REQ. i_deal while o_empty=1 is ignored.
- REQ: o_rand_request=1 for exactly this cycle -> WAIT.
- WAIT: one idle cycle so the generator's output settles after the request edge -> LOAD.
- LOAD: idx <= i_rand_value folded into range. If value >= 52, idx = value-52 (e.g. 60 -> 8) -> PROBE.
- PROBE: if mask[idx]=0, set mask[idx], decrement o_cards_left, register rank=idx%13+1 and suit=idx/13 -> DONE. If mask[idx]=1, idx <= (idx==51) ? 0 : idx+1 and stay in PROBE.
- DONE: o_card_valid=1 for one cycle; o_empty=1 if o_cards_left==0 -> IDLE.
- Latency: with i_deal sampled at edge N and a free first probe, o_card_valid is high in the cycle after edge N+4. Each occupied slot probed adds 1 cycle. Worst case is 51 extra cycles; the probe cannot loop forever because deals are never started when the deck is empty.
- i_shuffle (any state, including mid-deal): at the next edge, mask=0, o_cards_left=52, o_empty=0, state=IDLE, no o_card_valid for the aborted deal. Rank and suit hold their previous values.
- i_shuffle and i_deal in the same cycle: shuffle wins; the deal is dropped.
- i_deal held high: one card per IDLE visit, so consecutive deals start back-to-back.
- i_reset asserted mid-PROBE: immediate return to reset values; no partial mask update survives.

Decomposition:
- Package card_pkg: NUM_CARDS, RANKS_PER_SUIT=13, rank_t (4-bit), suit_t (2-bit) with suit encodings, dealer_state_t enum.
- Sub-module card_index_decode: combinational, index 0..51 -> {rank, suit}, using compare/subtract rather than generic divide. The dealer registers its outputs.

Test Plan:
- Reset then idle: o_cards_left=52, o_empty=0, o_busy=0, o_rand_max=51, and no o_rand_request pulses.
- Deal with i_rand_value=0: one o_rand_request pulse, then o_card_valid 5 cycles after i_deal with rank=1, suit=0; o_cards_left=51. Repeat with value 25: rank=13, suit=1.
- Collision and wrap: deal with value 5 twice; the second deal gives idx 6 (rank=7, suit=0) with latency +1. Then deal with 51, then 51 again; the second gives idx 0 only if 0 is still free, otherwise the next free index.
- Out-of-range value 60: card idx 8 (rank=9, suit=0).
- Exhaustion: 52 deals with random values produce 52 distinct {rank,suit} pairs. After the last, o_empty=1 and o_cards_left=0. A 53rd i_deal produces no o_rand_request and no o_card_valid.
- Shuffle during PROBE, and i_shuffle together with i_deal: no o_card_valid, o_cards_left=52, o_empty=0, state returns to IDLE. A following deal with value 5 returns rank=6, suit=0.
